// File: rtl/puf_batch_controller.sv
// SIRC user-side controller that runs a batch of PUF challenges per run request.
// It fetches each challenge byte-wise, drives the PUF engine, writes the response bytes and posts a status word.
module puf_batch_controller #(
  parameter int unsigned INMEM_ADDRESS_WIDTH  = 17,
  parameter int unsigned OUTMEM_ADDRESS_WIDTH = 13,
  parameter int unsigned CHAL_BYTES           = 8,
  parameter int unsigned RESP_BYTES           = 4,
  parameter int unsigned TIMEOUT_CYCLES       = 1024,
  parameter int unsigned STATUS_ADDR          = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            userRunValue,
  output logic                            userRunClear,
  output logic                            register32CmdReq,
  input  logic                            register32CmdAck,
  output logic [31:0]                     register32WriteData,
  output logic [7:0]                      register32Address,
  output logic                            register32WriteEn,
  input  logic                            register32ReadDataValid,
  input  logic [31:0]                     register32ReadData,
  output logic                            inputMemoryReadReq,
  input  logic                            inputMemoryReadAck,
  output logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
  input  logic                            inputMemoryReadDataValid,
  input  logic [7:0]                      inputMemoryReadData,
  output logic                            outputMemoryWriteReq,
  input  logic                            outputMemoryWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
  output logic [7:0]                      outputMemoryWriteData,
  output logic                            outputMemoryWriteByteMask,
  output logic                            puf_start,
  output logic [8*CHAL_BYTES-1:0]         puf_challenge,
  input  logic                            puf_done,
  input  logic [8*RESP_BYTES-1:0]         puf_response,
  output logic [7:0]                      LED
);

  localparam int unsigned CHAL_W    = 8 * CHAL_BYTES;
  localparam int unsigned RESP_W    = 8 * RESP_BYTES;
  localparam int unsigned MAX_BYTES = (CHAL_BYTES > RESP_BYTES) ? CHAL_BYTES : RESP_BYTES;
  localparam int unsigned BCNT_W    = $clog2(MAX_BYTES + 1);
  localparam int unsigned TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IA_W      = INMEM_ADDRESS_WIDTH;
  localparam int unsigned OA_W      = OUTMEM_ADDRESS_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RD_LEN     = 4'd1,
    S_RD_WAIT    = 4'd2,
    S_FETCH      = 4'd3,
    S_FETCH_WAIT = 4'd4,
    S_EVAL       = 4'd5,
    S_WRITE      = 4'd6,
    S_WRITE_GAP  = 4'd7,
    S_STATUS     = 4'd8
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic                r_reg_req,   w_reg_req_nxt;
  logic                r_reg_we,    w_reg_we_nxt;
  logic [7:0]          r_reg_addr,  w_reg_addr_nxt;
  logic [31:0]         r_reg_wdata, w_reg_wdata_nxt;
  logic                r_run_clear, w_run_clear_nxt;
  logic                r_in_req,    w_in_req_nxt;
  logic [IA_W-1:0]     r_in_addr,   w_in_addr_nxt;
  logic                r_out_req,   w_out_req_nxt;
  logic [OA_W-1:0]     r_out_addr,  w_out_addr_nxt;
  logic [7:0]          r_out_data,  w_out_data_nxt;
  logic                r_start,     w_start_nxt;
  logic [CHAL_W-1:0]   r_chal,      w_chal_nxt;
  logic [RESP_W-1:0]   r_resp,      w_resp_nxt;
  logic [15:0]         r_n,         w_n_nxt;
  logic [15:0]         r_idx,       w_idx_nxt;
  logic [15:0]         r_timeouts,  w_timeouts_nxt;
  logic [BCNT_W-1:0]   r_bcnt,      w_bcnt_nxt;
  logic [TCNT_W-1:0]   r_tcnt,      w_tcnt_nxt;
  logic                r_to_seen,   w_to_seen_nxt;
  logic [7:0]          r_led;
  logic                w_unused_ok;

  // Only the low half of the length register carries the batch size.
  assign w_unused_ok = &{1'b0, register32ReadData[31:16]};

  assign userRunClear              = r_run_clear;
  assign register32CmdReq          = r_reg_req;
  assign register32WriteEn         = r_reg_we;
  assign register32Address         = r_reg_addr;
  assign register32WriteData       = r_reg_wdata;
  assign inputMemoryReadReq        = r_in_req;
  assign inputMemoryReadAdd        = r_in_addr;
  assign outputMemoryWriteReq      = r_out_req;
  assign outputMemoryWriteAdd      = r_out_addr;
  assign outputMemoryWriteData     = r_out_data;
  assign outputMemoryWriteByteMask = 1'b1;
  assign puf_start                 = r_start;
  assign puf_challenge             = r_chal;
  assign LED                       = r_led;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_reg_req_nxt   = r_reg_req;
    w_reg_we_nxt    = r_reg_we;
    w_reg_addr_nxt  = r_reg_addr;
    w_reg_wdata_nxt = r_reg_wdata;
    w_run_clear_nxt = 1'b0;
    w_in_req_nxt    = r_in_req;
    w_in_addr_nxt   = r_in_addr;
    w_out_req_nxt   = r_out_req;
    w_out_addr_nxt  = r_out_addr;
    w_out_data_nxt  = r_out_data;
    w_start_nxt     = 1'b0;
    w_chal_nxt      = r_chal;
    w_resp_nxt      = r_resp;
    w_n_nxt         = r_n;
    w_idx_nxt       = r_idx;
    w_timeouts_nxt  = r_timeouts;
    w_bcnt_nxt      = r_bcnt;
    w_tcnt_nxt      = r_tcnt;
    w_to_seen_nxt   = r_to_seen;

    case (r_state)
      S_IDLE: begin
        // A clear still visible this cycle blocks re-sampling of the run bit
        if (userRunValue && !r_run_clear) begin
          w_state_nxt    = S_RD_LEN;
          w_reg_req_nxt  = 1'b1;
          w_reg_we_nxt   = 1'b0;
          w_reg_addr_nxt = 8'd0;
          w_to_seen_nxt  = 1'b0;
        end
      end
      S_RD_LEN: begin
        if (register32CmdAck) begin
          w_reg_req_nxt = 1'b0;
          w_state_nxt   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (register32ReadDataValid) begin
          w_n_nxt        = register32ReadData[15:0];
          w_idx_nxt      = 16'd0;
          w_timeouts_nxt = 16'd0;
          w_in_addr_nxt  = '0;
          w_out_addr_nxt = '0;
          w_bcnt_nxt     = '0;
          if (register32ReadData[15:0] == 16'd0) begin
            w_state_nxt     = S_STATUS;
            w_reg_req_nxt   = 1'b1;
            w_reg_we_nxt    = 1'b1;
            w_reg_addr_nxt  = 8'(STATUS_ADDR);
            w_reg_wdata_nxt = 32'd0;
          end else begin
            w_state_nxt  = S_FETCH;
            w_in_req_nxt = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (inputMemoryReadAck) begin
          w_in_req_nxt  = 1'b0;
          w_in_addr_nxt = r_in_addr + IA_W'(1);
          w_state_nxt   = S_FETCH_WAIT;
        end
      end
      S_FETCH_WAIT: begin
        if (inputMemoryReadDataValid) begin
          w_chal_nxt[{r_bcnt, 3'b000} +: 8] = inputMemoryReadData;
          if (r_bcnt == BCNT_W'(CHAL_BYTES - 1)) begin
            w_bcnt_nxt  = '0;
            w_start_nxt = 1'b1;
            w_tcnt_nxt  = '0;
            w_state_nxt = S_EVAL;
          end else begin
            w_bcnt_nxt   = r_bcnt + BCNT_W'(1);
            w_in_req_nxt = 1'b1;
            w_state_nxt  = S_FETCH;
          end
        end
      end
      S_EVAL: begin
        // done takes priority over a timeout in the same cycle
        if (puf_done) begin
          w_resp_nxt    = puf_response;
          w_out_req_nxt = 1'b1;
          w_state_nxt   = S_WRITE;
        end else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_resp_nxt     = '1;
          w_timeouts_nxt = r_timeouts + 16'd1;
          w_to_seen_nxt  = 1'b1;
          w_out_req_nxt  = 1'b1;
          w_state_nxt    = S_WRITE;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
      end
      S_WRITE: begin
        if (outputMemoryWriteAck) begin
          w_out_req_nxt  = 1'b0;
          w_out_addr_nxt = r_out_addr + OA_W'(1);
          w_state_nxt    = S_WRITE_GAP;
        end
      end
      S_WRITE_GAP: begin
        if (r_bcnt == BCNT_W'(RESP_BYTES - 1)) begin
          w_bcnt_nxt = '0;
          w_idx_nxt  = r_idx + 16'd1;
          if ((r_idx + 16'd1) == r_n) begin
            w_state_nxt     = S_STATUS;
            w_reg_req_nxt   = 1'b1;
            w_reg_we_nxt    = 1'b1;
            w_reg_addr_nxt  = 8'(STATUS_ADDR);
            w_reg_wdata_nxt = {r_timeouts, r_idx + 16'd1};
          end else begin
            w_state_nxt  = S_FETCH;
            w_in_req_nxt = 1'b1;
          end
        end else begin
          w_bcnt_nxt    = r_bcnt + BCNT_W'(1);
          w_out_req_nxt = 1'b1;
          w_state_nxt   = S_WRITE;
        end
      end
      S_STATUS: begin
        if (register32CmdAck) begin
          w_reg_req_nxt   = 1'b0;
          w_reg_we_nxt    = 1'b0;
          w_run_clear_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Response byte to present on the write port, LSB first
    if (w_state_nxt == S_WRITE) begin
      w_out_data_nxt = 8'(w_resp_nxt >> {w_bcnt_nxt, 3'b000});
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_reg_req   <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= 8'd0;
      r_reg_wdata <= 32'd0;
      r_run_clear <= 1'b0;
      r_in_req    <= 1'b0;
      r_in_addr   <= '0;
      r_out_req   <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= 8'd0;
      r_start     <= 1'b0;
      r_chal      <= '0;
      r_resp      <= '0;
      r_n         <= 16'd0;
      r_idx       <= 16'd0;
      r_timeouts  <= 16'd0;
      r_bcnt      <= '0;
      r_tcnt      <= '0;
      r_to_seen   <= 1'b0;
      r_led       <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_reg_req   <= w_reg_req_nxt;
      r_reg_we    <= w_reg_we_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_wdata <= w_reg_wdata_nxt;
      r_run_clear <= w_run_clear_nxt;
      r_in_req    <= w_in_req_nxt;
      r_in_addr   <= w_in_addr_nxt;
      r_out_req   <= w_out_req_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_start     <= w_start_nxt;
      r_chal      <= w_chal_nxt;
      r_resp      <= w_resp_nxt;
      r_n         <= w_n_nxt;
      r_idx       <= w_idx_nxt;
      r_timeouts  <= w_timeouts_nxt;
      r_bcnt      <= w_bcnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_to_seen   <= w_to_seen_nxt;
      r_led       <= {w_to_seen_nxt, 3'b000, w_state_nxt};
    end
  end

endmodule
